fir_tap_scheduler: RTL and testbench

Folded FIR engine controller: accepts one 32-bit signed sample per valid/ready handshake and time-multiplexes a single multiply-accumulate over all taps, one tap per cycle, from a circular sample buffer and a writable coefficient memory. It replaces the fully parallel 100-tap filter where area matters more than throughput. It sits between the sample source and the output sink, with a coefficient configuration port for loading taps at run time.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_tap_scheduler_if.sv | 29 ++
 rtl/fir_coef_ram.sv | 31 +++
 rtl/fir_tap_scheduler.sv | 108 ++++++++++
 tb/tb_fir_tap_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the folded FIR tap scheduler: default sizes, FSM states
// and the circular-buffer address helper.
package fir_pkg;

  localparam int N_TAPS_DEF = 100;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  // (ptr - k) mod n for 0 <= ptr, k < n; picks x[n-k] out of the circular buffer
  function automatic int mod_dec(input int ptr, input int k, input int n);
    int d;
    d = ptr - k;
    if (d < 0) d = d + n;
    return d;
  endfunction

endpackage

// File: rtl/fir_tap_scheduler_if.sv
// Sample, result and coefficient-configuration signals of the folded FIR engine.
interface fir_tap_scheduler_if #(
  parameter int DATA_W = fir_pkg::DATA_W_DEF,
  parameter int AW     = $clog2(fir_pkg::N_TAPS_DEF)
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              coef_wr_en;
  logic [AW-1:0]     coef_addr;
  logic [DATA_W-1:0] coef_data;
  logic              cfg_err;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready, coef_wr_en, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, cfg_err, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_wr_en, coef_addr, coef_data,
    output in_ready, out_valid, out_data, cfg_err, busy
  );

endinterface

// File: rtl/fir_coef_ram.sv
// Coefficient store: one synchronous write port, one combinational read port,
// asynchronously cleared to zero.
module fir_coef_ram
  import fir_pkg::*;
#(
  parameter int DEPTH  = N_TAPS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_tap_scheduler.sv
// Folded FIR controller: each accepted sample runs N_TAPS single-MAC cycles over a
// circular sample buffer and a run-time writable coefficient RAM.
module fir_tap_scheduler
  import fir_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = $clog2(N_TAPS)
) (
  input  logic               clk,
  input  logic               reset,
  fir_tap_scheduler_if.slave bus
);

  fir_state_t        state, next_state;
  logic [AW-1:0]     wr_ptr, k, samp_addr;
  logic [DATA_W-1:0] acc, out_data_q, coef_rd, samp_rd, product, mac_sum;
  logic [DATA_W-1:0] sample_mem [N_TAPS];
  logic              cfg_err_q, accept, last_tap, coef_ok, coef_drop;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_tap  = (k == AW'(N_TAPS - 1));
  assign samp_addr = AW'(mod_dec(int'(wr_ptr), int'(k), N_TAPS));
  assign coef_ok   = bus.coef_wr_en && (state == IDLE) && (int'(bus.coef_addr) < N_TAPS);
  assign coef_drop = bus.coef_wr_en && !coef_ok;
  assign samp_rd   = sample_mem[samp_addr];
  // Only the low DATA_W bits are kept, so signedness does not affect the result
  assign product   = coef_rd * samp_rd;
  assign mac_sum   = acc + product;

  fir_coef_ram #(
    .DEPTH (N_TAPS),
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_coef_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (coef_ok),
    .wr_addr(bus.coef_addr),
    .wr_data(bus.coef_data),
    .rd_addr(k),
    .rd_data(coef_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) next_state = MAC;
      end
      MAC: begin
        bus.busy = 1'b1;
        if (last_tap) next_state = OUT;
      end
      OUT: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Write pointer only moves once the frame is done, so every tap sees the same x[n]
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      k          <= '0;
      acc        <= '0;
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= coef_drop;
      if (accept) begin
        acc <= '0;
        k   <= '0;
      end else if (state == MAC) begin
        acc <= mac_sum;
        k   <= k + 1'b1;
        if (last_tap) begin
          out_data_q <= mac_sum;
          wr_ptr     <= (wr_ptr == AW'(N_TAPS - 1)) ? '0 : wr_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) sample_mem[i] <= '0;
    end else if (accept) begin
      sample_mem[wr_ptr] <= bus.in_data;
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Self-checking bench for fir_tap_scheduler: a history-based FIR model fills a
// scoreboard at every accept, and a negedge monitor pops it on each result.
module tb_fir_tap_scheduler;
  import fir_pkg::*;

  localparam int N  = 100;
  localparam int DW = 32;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_tap_scheduler_if #(.DATA_W(DW), .AW(AW)) bus ();

  fir_tap_scheduler #(.N_TAPS(N), .DATA_W(DW), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_accept = 0;

  logic [DW-1:0] h_m [N];
  logic [DW-1:0] hist [$];
  logic [DW-1:0] exp_q [$];
  int            acc_cyc_q [$];

  always @(posedge clk) cyc++;

  task automatic model_reset();
    for (int i = 0; i < N; i++) h_m[i] = '0;
    hist.delete();
    exp_q.delete();
    acc_cyc_q.delete();
  endtask

  // y[n] = sum h[k]*x[n-k], with hist holding the newest sample first
  task automatic model_accept(input logic [DW-1:0] s);
    logic [DW-1:0] y;
    hist.push_front(s);
    if (hist.size() > N) void'(hist.pop_back());
    y = '0;
    for (int i = 0; i < hist.size(); i++) y = y + h_m[i] * hist[i];
    exp_q.push_back(y);
    acc_cyc_q.push_back(cyc);
  endtask

  logic          prev_ov = 1'b0;
  logic [DW-1:0] mon_exp;
  int            mon_lat;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && !prev_ov) begin
        checks++;
        if (acc_cyc_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL latency: out_valid rose with no pending accept, required no output");
        end else begin
          mon_lat = cyc - acc_cyc_q[0];
          if (mon_lat !== N) begin
            failures++;
            $display("[TB] FAIL latency: got %0d cycles, required %0d", mon_lat, N);
          end
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL out_data: unexpected result %h, required none", bus.out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (acc_cyc_q.size() != 0) void'(acc_cyc_q.pop_front());
          if (bus.out_data !== mon_exp) begin
            failures++;
            $display("[TB] FAIL out_data: got %h, required %h", bus.out_data, mon_exp);
          end
        end
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic applyStimulus(input logic [DW-1:0] s, input string tag);
    bit got;
    got = 1'b0;
    bus.in_data  = s;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4 * N; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s accept: in_ready=0 after %0d cycles, required 1", tag, 4 * N);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      model_accept(s);
      last_accept = cyc;
    end
  endtask

  task automatic write_coef(input int addr, input logic [DW-1:0] data, input bit accepted);
    bus.coef_addr  = AW'(addr);
    bus.coef_data  = data;
    bus.coef_wr_en = 1'b1;
    @(posedge clk);
    #1;
    bus.coef_wr_en = 1'b0;
    if (accepted) h_m[addr] = data;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4 * N && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s drain: %0d results outstanding, required 0", tag, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input string tag);
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.coef_wr_en = 1'b0;
    @(negedge clk);
    checks += 5;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL %s in_ready: got %b, required 1", tag, bus.in_ready);
    end
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL %s out_valid: got %b, required 0", tag, bus.out_valid);
    end
    if (bus.out_data !== '0) begin
      failures++; $display("[TB] FAIL %s out_data: got %h, required 0", tag, bus.out_data);
    end
    if (bus.cfg_err !== 1'b0) begin
      failures++; $display("[TB] FAIL %s cfg_err: got %b, required 0", tag, bus.cfg_err);
    end
    if (bus.busy !== 1'b0) begin
      failures++; $display("[TB] FAIL %s busy: got %b, required 0", tag, bus.busy);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s post_release: in_ready=%b busy=%b, required 1/0", tag, bus.in_ready, bus.busy);
    end
  endtask

  // Impulse through h[k]=k+1 with out_ready tied high: 1..N then 0, accepts N+2 apart
  task automatic test_impulse_back_to_back(input string tag);
    int prev;
    for (int i = 0; i < N; i++) write_coef(i, DW'(i + 1), 1'b1);
    bus.out_ready = 1'b1;
    applyStimulus(DW'(1), tag);
    for (int i = 0; i < N; i++) begin
      prev = last_accept;
      applyStimulus('0, tag);
      checks++;
      if (last_accept - prev !== N + 2) begin
        failures++;
        $display("[TB] FAIL %s spacing: got %0d cycles, required %0d", tag, last_accept - prev, N + 2);
      end
    end
    wait_drain(tag);
  endtask

  task automatic test_ramp();
    for (int i = 0; i < N; i++) write_coef(i, DW'(1), 1'b1);
    for (int i = 0; i < N + 2; i++) applyStimulus(DW'(5), "ramp");
    wait_drain("ramp");
  endtask

  task automatic test_wrap_arith();
    test_reset("pre_wrap");
    write_coef(0, 32'h7FFF_FFFF, 1'b1);
    write_coef(1, 32'h0000_0002, 1'b1);
    applyStimulus(DW'(2), "wrap");
    applyStimulus(DW'(2), "wrap");
    wait_drain("wrap");
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(DW'(3), "hold");
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL hold out_valid: got 0 after %0d cycles, required 1", 2 * N);
    end
    for (int i = 0; i < 20; i++) begin
      checks += 3;
      if (bus.out_valid !== 1'b1) begin
        failures++; $display("[TB] FAIL hold out_valid cycle %0d: got %b, required 1", i, bus.out_valid);
      end
      if (exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin
        failures++; $display("[TB] FAIL hold out_data cycle %0d: got %h, required pending result", i, bus.out_data);
      end
      if (bus.in_ready !== 1'b0) begin
        failures++; $display("[TB] FAIL hold in_ready cycle %0d: got %b, required 0", i, bus.in_ready);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cfg_err();
    bus.out_ready = 1'b1;
    applyStimulus(DW'(7), "cfg_mac");
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("[TB] FAIL cfg_mac busy: got %b, required 1", bus.busy);
    end
    write_coef(1, 32'h0000_1234, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.cfg_err !== 1'b1) begin
      failures++; $display("[TB] FAIL cfg_mac cfg_err: got %b, required 1", bus.cfg_err);
    end
    @(negedge clk);
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      failures++; $display("[TB] FAIL cfg_mac cfg_err_end: got %b, required 0", bus.cfg_err);
    end
    wait_drain("cfg_mac");

    write_coef(N, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.cfg_err !== 1'b1) begin
      failures++; $display("[TB] FAIL cfg_range cfg_err: got %b, required 1", bus.cfg_err);
    end
    @(negedge clk);
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      failures++; $display("[TB] FAIL cfg_range cfg_err_end: got %b, required 0", bus.cfg_err);
    end
    @(posedge clk);
    #1;
    write_coef(2, DW'(5), 1'b1);
    @(negedge clk);
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      failures++; $display("[TB] FAIL cfg_ok cfg_err: got %b, required 0", bus.cfg_err);
    end

    // Coefficient write and sample accept in the same IDLE cycle
    @(posedge clk);
    #1;
    bus.in_data    = DW'(4);
    bus.in_valid   = 1'b1;
    bus.coef_addr  = AW'(0);
    bus.coef_data  = DW'(3);
    bus.coef_wr_en = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL same_cycle in_ready: got %b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.coef_wr_en = 1'b0;
    h_m[0] = DW'(3);
    model_accept(DW'(4));
    last_accept = cyc;
    applyStimulus('0, "cfg_check");
    applyStimulus(DW'(1), "cfg_check");
    wait_drain("cfg_check");
  endtask

  task automatic test_reset_mid_frame();
    test_reset("pre_mid");
    for (int i = 0; i < N; i++) write_coef(i, DW'(i + 1), 1'b1);
    bus.out_ready = 1'b1;
    applyStimulus(DW'(1), "mid_frame");
    repeat (37) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("[TB] FAIL mid_frame busy: got %b, required 1", bus.busy);
    end
    test_reset("mid_frame");
    repeat (N + 5) @(negedge clk);
    @(posedge clk);
    #1;
    test_impulse_back_to_back("after_reset");
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus.coef_wr_en = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_data  = '0;
    model_reset();

    test_reset("power_on");
    test_impulse_back_to_back("impulse");
    test_ramp();
    test_wrap_arith();
    test_backpressure();
    test_cfg_err();
    test_reset_mid_frame();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
